// File: rtl/tdm_io_bridge.sv
// Master-mode TDM serial port bridging ADC/DAC slots to the DSP io memory.
// Generates bclk/fsync, writes received slots, prefetches words to transmit.
module tdm_io_bridge #(
    parameter int CHANNELS      = 8,
    parameter int IO_WIDTH      = 24,
    parameter int SLOT_WIDTH    = 32,
    parameter int BCLK_DIV      = 4,
    parameter int IO_ADDR_WIDTH = 10,
    parameter int IN_BASE       = 0,
    parameter int OUT_BASE      = 8,
    parameter int RD_LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    output logic                     bclk,
    output logic                     fsync,
    input  logic                     sdata_in,
    output logic                     sdata_out,
    output logic                     mem_wr_en,
    output logic [IO_ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [IO_WIDTH-1:0]      mem_wr_data,
    output logic                     mem_rd_en,
    output logic [IO_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [IO_WIDTH-1:0]      mem_rd_data,
    output logic                     sample_tick
);

    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(SLOT_WIDTH);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = IO_ADDR_WIDTH;

    logic [DW-1:0]         r_div_cnt;
    logic                  r_bclk;
    logic [BW-1:0]         r_bit_cnt;
    logic [SW-1:0]         r_slot_cnt;
    logic                  r_fsync;
    logic [IO_WIDTH-2:0]   r_rx_sh;
    logic [IO_WIDTH-1:0]   r_tx_sh;
    logic [IO_WIDTH-1:0]   r_tx_hold;
    logic                  r_first;
    logic                  r_wr_en;
    logic [AW-1:0]         r_wr_addr;
    logic [IO_WIDTH-1:0]   r_wr_data;
    logic                  r_tick;
    logic                  r_rd_en;
    logic [AW-1:0]         r_rd_addr;
    logic [RD_LATENCY-1:0] r_rd_v;

    logic                w_tgl;
    logic                w_rise;
    logic                w_fall;
    logic                w_bit_wrap;
    logic                w_slot_wrap;
    logic [BW-1:0]       w_bit_nx;
    logic [SW-1:0]       w_slot_nx;
    logic [SW-1:0]       w_slot_inc;
    logic [IO_WIDTH-1:0] w_rx_word;
    logic                w_rx_last;
    logic                w_pf;
    logic                w_issue;

    assign w_tgl       = (r_div_cnt == DW'(BCLK_DIV - 1));
    assign w_rise      = w_tgl & ~r_bclk;
    assign w_fall      = w_tgl & r_bclk;
    assign w_bit_wrap  = (r_bit_cnt == BW'(SLOT_WIDTH - 1));
    assign w_slot_wrap = (r_slot_cnt == SW'(CHANNELS - 1));
    assign w_slot_inc  = w_slot_wrap ? '0 : r_slot_cnt + SW'(1);
    assign w_rx_word   = {r_rx_sh, sdata_in};
    assign w_rx_last   = w_rise && (r_bit_cnt == BW'(IO_WIDTH - 1));
    assign w_pf        = w_fall && (r_bit_cnt == BW'(SLOT_WIDTH - 2));
    assign w_issue     = enable & w_pf;

    always_comb begin
        w_bit_nx  = r_bit_cnt;
        w_slot_nx = r_slot_cnt;
        if (w_fall) begin
            w_bit_nx = w_bit_wrap ? '0 : r_bit_cnt + BW'(1);
            if (w_bit_wrap)
                w_slot_nx = w_slot_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_bit_cnt  <= '0;
            r_slot_cnt <= '0;
            r_fsync    <= 1'b0;
            r_rx_sh    <= '0;
            r_tx_sh    <= '0;
            r_tx_hold  <= '0;
            r_first    <= 1'b1;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_tick     <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_v     <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_tick  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_v  <= (r_rd_v << 1) | RD_LATENCY'(w_issue);
            if (r_rd_v[RD_LATENCY-1])
                r_tx_hold <= mem_rd_data;
            if (!enable) begin
                r_div_cnt  <= '0;
                r_bclk     <= 1'b0;
                r_bit_cnt  <= '0;
                r_slot_cnt <= '0;
                r_fsync    <= 1'b1;
                r_rx_sh    <= '0;
                r_tx_sh    <= '0;
                r_tx_hold  <= '0;
                r_first    <= 1'b1;
            end else begin
                r_div_cnt  <= w_tgl ? '0 : r_div_cnt + DW'(1);
                r_bit_cnt  <= w_bit_nx;
                r_slot_cnt <= w_slot_nx;
                r_fsync    <= (w_bit_nx == '0) && (w_slot_nx == '0);
                if (w_tgl)
                    r_bclk <= ~r_bclk;
                if (w_rise && (r_bit_cnt < BW'(IO_WIDTH)))
                    r_rx_sh <= w_rx_word[IO_WIDTH-2:0];
                if (w_rx_last) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= AW'(IN_BASE) + AW'(r_slot_cnt);
                    r_wr_data <= w_rx_word;
                    r_tick    <= w_slot_wrap;
                end
                // No prefetch precedes the first frame, so it sends silence.
                if (w_fall) begin
                    if (w_bit_wrap) begin
                        r_tx_sh <= (r_first && !w_slot_wrap) ? '0 : r_tx_hold;
                        if (w_slot_wrap)
                            r_first <= 1'b0;
                    end else begin
                        r_tx_sh <= r_tx_sh << 1;
                    end
                end
                if (w_pf) begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= AW'(OUT_BASE) + AW'(w_slot_inc);
                end
            end
        end
    end

    assign bclk        = r_bclk;
    assign fsync       = r_fsync;
    assign sdata_out   = r_tx_sh[IO_WIDTH-1];
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign sample_tick = r_tick;

endmodule

// File: tb/tb_tdm_io_bridge.sv
// Bench for tdm_io_bridge: frame-position reference model driven by a
// count of enabled clock edges, plus directed enable/reset disruptions.
module tb_tdm_io_bridge;

    localparam int CH    = 8;
    localparam int IOW   = 24;
    localparam int SLW   = 32;
    localparam int DIV   = 4;
    localparam int AW    = 10;
    localparam int INB   = 0;
    localparam int OUTB  = 8;
    localparam int RL    = 2;
    localparam int SLOTC = SLW * 2 * DIV;
    localparam int FRAME = CH * SLOTC;
    localparam int WROFF = (IOW - 1) * 2 * DIV + DIV;
    localparam int RDOFF = (SLW - 1) * 2 * DIV;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           enable;
    logic           bclk;
    logic           fsync;
    logic           sdata_in;
    logic           sdata_out;
    logic           mem_wr_en;
    logic [AW-1:0]  mem_wr_addr;
    logic [IOW-1:0] mem_wr_data;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_rd_addr;
    logic [IOW-1:0] mem_rd_data = '0;
    logic           sample_tick;

    tdm_io_bridge #(
        .CHANNELS(CH), .IO_WIDTH(IOW), .SLOT_WIDTH(SLW), .BCLK_DIV(DIV),
        .IO_ADDR_WIDTH(AW), .IN_BASE(INB), .OUT_BASE(OUTB),
        .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .bclk(bclk), .fsync(fsync),
        .sdata_in(sdata_in), .sdata_out(sdata_out),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [IOW-1:0] omem    [0:CH-1];
    logic [IOW-1:0] rx_word [0:CH-1];
    logic           loop = 1'b0;
    logic           mon  = 1'b0;
    logic           pat;
    int             en_edges = 0;
    longint         cyc = 0;
    int err_clk = 0, err_sd = 0, err_wr = 0, err_rd = 0, err_tk = 0;
    int s_clk, s_sd, s_wr, s_rd, s_tk;
    int             wa_q [$];
    logic [IOW-1:0] wd_q [$];
    int             rd_q [$];
    longint         tk_q [$];

    function automatic logic [IOW-1:0] rd_lookup(logic [AW-1:0] a);
        if (int'(a) >= OUTB && int'(a) < OUTB + CH)
            return omem[int'(a) - OUTB];
        return '0;
    endfunction

    // Memory with a registered read port; data is held until the next read.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        en_edges <= (enable && reset_n) ? en_edges + 1 : 0;
        if (mem_rd_en)
            mem_rd_data <= rd_lookup(mem_rd_addr);
    end

    // ADC model: bit b of slot s is the b-th MSB of rx_word[s], then zeros.
    always_comb begin
        int p, b, s;
        p   = en_edges / (2 * DIV);
        b   = p % SLW;
        s   = (p / SLW) % CH;
        pat = 1'b0;
        if (b < IOW)
            pat = rx_word[s][IOW-1-b];
    end
    assign sdata_in = loop ? sdata_out : pat;

    always @(negedge clk) begin
        if (sample_tick) tk_q.push_back(cyc);
        if (mem_rd_en)   rd_q.push_back(int'(mem_rd_addr));
        if (mem_wr_en) begin
            wa_q.push_back(int'(mem_wr_addr));
            wd_q.push_back(mem_wr_data);
        end
    end

    // Reference: every output is a function of the enabled-edge count.
    always @(negedge clk) begin
        int e, f, s, b;
        logic [IOW-1:0] w;
        logic [IOW-1:0] rxw;
        logic xsd;
        if (mon && enable && reset_n) begin
            e   = en_edges;
            f   = e / FRAME;
            s   = (e / SLOTC) % CH;
            b   = (e / (2 * DIV)) % SLW;
            w   = (f == 0) ? '0 : omem[s];
            rxw = loop ? w : rx_word[s];
            xsd = (b < IOW) ? w[IOW-1-b] : 1'b0;
            if (bclk !== 1'((e / DIV) % 2) ||
                fsync !== ((e % FRAME) < 2 * DIV))
                err_clk <= err_clk + 1;
            if (sdata_out !== xsd)
                err_sd <= err_sd + 1;
            if (mem_wr_en !== ((e % SLOTC) == WROFF))
                err_wr <= err_wr + 1;
            else if (mem_wr_en && (mem_wr_addr !== AW'(INB + s) ||
                                   mem_wr_data !== rxw))
                err_wr <= err_wr + 1;
            if (sample_tick !== ((e % FRAME) == (CH - 1) * SLOTC + WROFF))
                err_tk <= err_tk + 1;
            if (mem_rd_en !== ((e % SLOTC) == RDOFF))
                err_rd <= err_rd + 1;
            else if (mem_rd_en && mem_rd_addr !== AW'(OUTB + (s + 1) % CH))
                err_rd <= err_rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        s_clk = err_clk; s_sd = err_sd; s_wr = err_wr;
        s_rd = err_rd;  s_tk = err_tk;
    endtask

    task automatic chk_mon(input string ph);
        chk({ph, "_bclk_fsync"}, 64'(err_clk - s_clk), 0);
        chk({ph, "_sdata_out"},  64'(err_sd - s_sd),   0);
        chk({ph, "_writes"},     64'(err_wr - s_wr),   0);
        chk({ph, "_reads"},      64'(err_rd - s_rd),   0);
        chk({ph, "_tick"},       64'(err_tk - s_tk),   0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {bclk, fsync, sdata_out, mem_wr_en,
                            mem_rd_en, sample_tick}, 0);
        chk({tag, "_bus"}, {mem_wr_addr, mem_rd_addr, mem_wr_data}, 0);
    endtask

    initial begin
        int w0, r0, t0, waited, strobes;
        reset_n = 1'b0;
        enable  = 1'b0;
        for (int k = 0; k < CH; k++) begin
            omem[k]    = '0;
            rx_word[k] = '0;
        end
        #12;
        chk_all_zero("reset");
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("idle_fsync", fsync, 1);
        chk("idle_bclk", bclk, 0);

        // Zero memory, one marked ADC slot.
        rx_word[3] = 24'h800001;
        w0 = wa_q.size();
        t0 = tk_q.size();
        snap();
        enable = 1'b1;
        mon    = 1'b1;
        repeat (FRAME) step();
        enable = 1'b0;
        repeat (4) step();
        chk_mon("A");
        chk("A_nwrites", 64'(wa_q.size() - w0), CH);
        for (int k = 0; k < CH; k++) begin
            chk("A_wr_addr", 64'(wa_q[w0+k]), 64'(INB + k));
            chk("A_wr_data", 64'(wd_q[w0+k]), (k == 3) ? 64'h800001 : 64'h0);
        end
        chk("A_nticks", 64'(tk_q.size() - t0), 1);

        // Known output words, random ADC words, three frames.
        for (int k = 0; k < CH; k++) begin
            omem[k]    = IOW'(24'h10000 + k);
            rx_word[k] = IOW'($urandom);
        end
        r0 = rd_q.size();
        snap();
        enable = 1'b1;
        repeat (3 * FRAME) step();
        enable = 1'b0;
        repeat (4) step();
        chk_mon("B");
        for (int k = 0; k < CH; k++)
            chk("B_rd_addr", 64'(rd_q[r0+k]), 64'(OUTB + (k + 1) % CH));

        // Loopback with random memory words.
        for (int k = 0; k < CH; k++)
            omem[k] = IOW'($urandom);
        loop = 1'b1;
        t0 = tk_q.size();
        snap();
        enable = 1'b1;
        repeat (3 * FRAME) step();
        enable = 1'b0;
        repeat (4) step();
        loop = 1'b0;
        chk_mon("C");
        chk("C_nticks", 64'(tk_q.size() - t0), 3);
        chk("C_tick_gap1", 64'(tk_q[t0+1] - tk_q[t0]), FRAME);
        chk("C_tick_gap2", 64'(tk_q[t0+2] - tk_q[t0+1]), FRAME);

        // Enable dropped at slot 4 bit 10, then restarted.
        for (int k = 0; k < CH; k++)
            rx_word[k] = IOW'($urandom);
        snap();
        enable = 1'b1;
        repeat (4 * SLOTC + 10 * 2 * DIV) step();
        enable = 1'b0;
        step();
        chk("D_idle_bclk", bclk, 0);
        chk("D_idle_fsync", fsync, 1);
        strobes = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (mem_wr_en || mem_rd_en || sample_tick)
                strobes++;
        end
        chk("D_no_strobes", 64'(strobes), 0);
        enable = 1'b1;
        waited = 0;
        while (!mem_wr_en && waited < 400) begin
            step();
            waited++;
        end
        chk("D_first_wr_lat", 64'(waited), WROFF);
        chk("D_first_wr_addr", 64'(mem_wr_addr), INB);
        repeat (FRAME) step();
        enable = 1'b0;
        repeat (4) step();
        chk_mon("D");

        // Reset asserted right after a prefetch strobe.
        for (int k = 0; k < CH; k++)
            omem[k] = IOW'($urandom);
        enable = 1'b1;
        waited = 0;
        while (!mem_rd_en && waited < 400) begin
            step();
            waited++;
        end
        chk("E_rd_seen", mem_rd_en, 1);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk_all_zero("E_reset");
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        snap();
        enable = 1'b1;
        repeat (2 * FRAME) step();
        enable = 1'b0;
        repeat (4) step();
        chk_mon("E");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
